// File: rtl/consumidor_destinos_pkg.sv
// Shared types and constants for the destination-FIFO egress reader.
// Optional counters are controlled by CONSUMIDOR_CONTADORES_EN in the top file.
package consumidor_destinos_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  localparam int OUT_DEPTH = 2;

  // Buffer slots already spoken for, net of the word leaving this cycle.
  function automatic logic [2:0] credit_occ(input logic [1:0] count,
                                            input logic       in_flight,
                                            input logic       drain);
    return {1'b0, count} + {2'b00, in_flight} - {2'b00, drain};
  endfunction

endpackage

// File: rtl/consumidor_destinos_buffer_salida_2.sv
// Two-entry {tag, data} output FIFO; slot0 is always the head so it can drive
// the outputs straight from a register.
module buffer_salida_2
  import consumidor_destinos_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] slot0_r;
  logic [W-1:0] slot1_r;
  logic [1:0]   count_r;
  logic         do_pop_s;
  logic         do_push_s;

  assign do_pop_s  = pop & (count_r != 2'd0);
  assign do_push_s = push & ((count_r != 2'(OUT_DEPTH)) | do_pop_s);

  // Shift-style storage: a pop moves slot1 into the head slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_r <= {W{1'b0}};
      slot1_r <= {W{1'b0}};
      count_r <= 2'd0;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            slot0_r <= push_data;
          end else begin
            slot1_r <= push_data;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          slot0_r <= slot1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            slot0_r <= push_data;
          end else begin
            slot0_r <= slot1_r;
            slot1_r <= push_data;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign full  = (count_r == 2'(OUT_DEPTH));
  assign empty = (count_r == 2'd0);
  assign count = count_r;
  assign head  = slot0_r;

endmodule

// File: rtl/consumidor_destinos.sv
// Round-robin egress reader for destination FIFOs D0/D1 with a 2-entry tagged
// output buffer. Define CONSUMIDOR_CONTADORES_EN to build the per-destination pop counters.
module consumidor_destinos
  import consumidor_destinos_pkg::*;
#(
  parameter int BITNUMBER = 8,
  parameter int CNTW      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 D0_can_pop,
  input  logic                 D1_can_pop,
  input  logic [BITNUMBER-1:0] data_D0,
  input  logic [BITNUMBER-1:0] data_D1,
  input  logic                 sink_ready,
  output logic                 pop_D0,
  output logic                 pop_D1,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  output logic                 dest_out,
  output logic [CNTW-1:0]      cnt_D0,
  output logic [CNTW-1:0]      cnt_D1,
  output logic                 idle
);

  state_t               state_r;
  state_t               state_next_s;
  logic                 last_grant_r;
  logic                 in_flight_r;
  logic                 in_flight_src_r;
  logic                 idle_r;
  logic                 grant_s;
  logic                 grant_src_s;
  logic                 drain_s;
  logic                 credit_ok_s;
  logic                 buf_full_s;
  logic                 buf_empty_s;
  logic                 buf_push_s;
  logic [1:0]           buf_count_s;
  logic [1:0]           count_next_s;
  logic [BITNUMBER:0]   push_word_s;
  logic [BITNUMBER:0]   head_s;

  assign valid_out   = ~buf_empty_s;
  assign drain_s     = valid_out & sink_ready;
  assign credit_ok_s = (credit_occ(buf_count_s, in_flight_r, drain_s) < 3'd2);

  // FSM next state: init alone moves between IDLE and ACTIVE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (init) begin
          state_next_s = ACTIVE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACTIVE: begin
        if (!init) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Round-robin grant; on contention the side that did not win last time goes.
  always_comb begin
    grant_s     = 1'b0;
    grant_src_s = DEST_D0;
    if ((state_r == ACTIVE) && credit_ok_s && reset) begin
      case ({D1_can_pop, D0_can_pop})
        2'b01: begin
          grant_s     = 1'b1;
          grant_src_s = DEST_D0;
        end
        2'b10: begin
          grant_s     = 1'b1;
          grant_src_s = DEST_D1;
        end
        2'b11: begin
          grant_s     = 1'b1;
          grant_src_s = (last_grant_r == DEST_D1) ? DEST_D0 : DEST_D1;
        end
        default: begin
          grant_s     = 1'b0;
          grant_src_s = DEST_D0;
        end
      endcase
    end else begin
      grant_s     = 1'b0;
      grant_src_s = DEST_D0;
    end
  end

  assign pop_D0 = grant_s & (grant_src_s == DEST_D0);
  assign pop_D1 = grant_s & (grant_src_s == DEST_D1);

  assign buf_push_s   = in_flight_r & (~buf_full_s | drain_s);
  assign push_word_s  = (in_flight_src_r == DEST_D1) ? {DEST_D1, data_D1} : {DEST_D0, data_D0};
  assign count_next_s = buf_count_s + {1'b0, buf_push_s} - {1'b0, drain_s};

  // Control state: FSM, arbitration history, in-flight tracking and idle flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= IDLE;
      last_grant_r    <= DEST_D1;
      in_flight_r     <= 1'b0;
      in_flight_src_r <= DEST_D0;
      idle_r          <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      in_flight_r <= grant_s;
      if (grant_s) begin
        last_grant_r    <= grant_src_s;
        in_flight_src_r <= grant_src_s;
      end else begin
        last_grant_r    <= last_grant_r;
        in_flight_src_r <= in_flight_src_r;
      end
      idle_r <= (state_next_s == IDLE) & ~grant_s & (count_next_s == 2'd0);
    end
  end

  assign idle = idle_r;

  buffer_salida_2 #(
    .W(BITNUMBER + 1)
  ) u_buffer (
    .clk       (clk),
    .rst_n     (reset),
    .push      (buf_push_s),
    .push_data (push_word_s),
    .pop       (drain_s),
    .full      (buf_full_s),
    .empty     (buf_empty_s),
    .count     (buf_count_s),
    .head      (head_s)
  );

  assign data_out = head_s[BITNUMBER-1:0];
  assign dest_out = head_s[BITNUMBER];

`ifdef CONSUMIDOR_CONTADORES_EN
  logic [CNTW-1:0] cnt_d0_r;
  logic [CNTW-1:0] cnt_d1_r;

  // Counters track pops at issue time and wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_d0_r <= {CNTW{1'b0}};
      cnt_d1_r <= {CNTW{1'b0}};
    end else begin
      if (pop_D0) begin
        cnt_d0_r <= cnt_d0_r + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        cnt_d0_r <= cnt_d0_r;
      end
      if (pop_D1) begin
        cnt_d1_r <= cnt_d1_r + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        cnt_d1_r <= cnt_d1_r;
      end
    end
  end

  assign cnt_D0 = cnt_d0_r;
  assign cnt_D1 = cnt_d1_r;
`else
  assign cnt_D0 = {CNTW{1'b0}};
  assign cnt_D1 = {CNTW{1'b0}};
`endif

endmodule
